mem_arbiter: RTL and testbench

- Two-to-one arbiter that shares the single data memory port between the instruction fetch unit (IFU) and the load/store path (LSU).
- Accepts one request at a time from either requester and forwards it to the memory port with a valid/ready handshake.
- Returns the response, or a timeout error, only to the requester that issued it.
- Sits between IFU/MEM and the memory model, replacing their direct memory access for the upcoming multi-cycle core.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin 2:1 arbiter sharing one memory port between IFU and LSU.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_req_valid,
   output logic             ifu_req_ready,
   input  logic [WIDTH-1:0] ifu_addr,
   output logic             ifu_resp_valid,
   output logic [WIDTH-1:0] ifu_rdata,
   output logic             ifu_err,
   input  logic             lsu_req_valid,
   output logic             lsu_req_ready,
   input  logic [WIDTH-1:0] lsu_addr,
   input  logic             lsu_wen,
   input  logic [WIDTH-1:0] lsu_wdata,
   input  logic [3:0]       lsu_wmask,
   output logic             lsu_resp_valid,
   output logic [WIDTH-1:0] lsu_rdata,
   output logic             lsu_err,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wen,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_wmask,
   input  logic             mem_resp_valid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // The counter only has to reach TIMEOUT-1.
   localparam int                 c_CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   localparam logic               c_OWN_IFU  = 1'b0;
   localparam logic               c_OWN_LSU  = 1'b1;

   state_t             r_state;
   logic               r_owner;
   logic               r_rr_last;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_mem_req_valid;
   logic [WIDTH-1:0]   r_mem_addr;
   logic               r_mem_wen;
   logic [WIDTH-1:0]   r_mem_wdata;
   logic [3:0]         r_mem_wmask;
   logic               r_ifu_resp_valid;
   logic [WIDTH-1:0]   r_ifu_rdata;
   logic               r_ifu_err;
   logic               r_lsu_resp_valid;
   logic [WIDTH-1:0]   r_lsu_rdata;
   logic               r_lsu_err;

   logic               w_grant_ifu;
   logic               w_grant_lsu;
   logic               w_wait_done;
   logic [WIDTH-1:0]   w_resp_rdata;
   logic               w_resp_err;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      w_grant_ifu = 1'b0;
      w_grant_lsu = 1'b0;
      if (!rst && r_state == S_IDLE) begin
         if (ifu_req_valid && (!lsu_req_valid || r_rr_last == c_OWN_LSU)) begin
            w_grant_ifu = 1'b1;
         end else if (lsu_req_valid) begin
            w_grant_lsu = 1'b1;
         end
      end
   end

   // A real response beats a coincident timeout; writes return zero data.
   always_comb begin
      w_wait_done  = mem_resp_valid || (r_cnt == c_CNT_LAST);
      w_resp_err   = !mem_resp_valid;
      w_resp_rdata = (mem_resp_valid && !r_mem_wen) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_owner          <= c_OWN_IFU;
         r_rr_last        <= c_OWN_LSU;
         r_cnt            <= '0;
         r_mem_req_valid  <= 1'b0;
         r_mem_addr       <= '0;
         r_mem_wen        <= 1'b0;
         r_mem_wdata      <= '0;
         r_mem_wmask      <= 4'b0000;
         r_ifu_resp_valid <= 1'b0;
         r_ifu_rdata      <= '0;
         r_ifu_err        <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_lsu_rdata      <= '0;
         r_lsu_err        <= 1'b0;
      end else begin
         r_ifu_resp_valid <= 1'b0;
         r_ifu_rdata      <= '0;
         r_ifu_err        <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_lsu_rdata      <= '0;
         r_lsu_err        <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_ifu) begin
                  r_mem_addr      <= ifu_addr;
                  r_mem_wen       <= 1'b0;
                  r_mem_wdata     <= '0;
                  r_mem_wmask     <= 4'b0000;
                  r_owner         <= c_OWN_IFU;
                  r_rr_last       <= c_OWN_IFU;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= S_REQ;
               end else if (w_grant_lsu) begin
                  r_mem_addr      <= lsu_addr;
                  r_mem_wen       <= lsu_wen;
                  r_mem_wdata     <= lsu_wdata;
                  r_mem_wmask     <= lsu_wmask;
                  r_owner         <= c_OWN_LSU;
                  r_rr_last       <= c_OWN_LSU;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_cnt           <= '0;
                  r_state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + c_CNT_W'(1);
               if (w_wait_done) begin
                  if (r_owner == c_OWN_IFU) begin
                     r_ifu_resp_valid <= 1'b1;
                     r_ifu_rdata      <= w_resp_rdata;
                     r_ifu_err        <= w_resp_err;
                  end else begin
                     r_lsu_resp_valid <= 1'b1;
                     r_lsu_rdata      <= w_resp_rdata;
                     r_lsu_err        <= w_resp_err;
                  end
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ifu_req_ready  = w_grant_ifu;
   assign lsu_req_ready  = w_grant_lsu;
   assign ifu_resp_valid = r_ifu_resp_valid;
   assign ifu_rdata      = r_ifu_rdata;
   assign ifu_err        = r_ifu_err;
   assign lsu_resp_valid = r_lsu_resp_valid;
   assign lsu_rdata      = r_lsu_rdata;
   assign lsu_err        = r_lsu_err;
   assign mem_req_valid  = r_mem_req_valid;
   assign mem_addr       = r_mem_addr;
   assign mem_wen        = r_mem_wen;
   assign mem_wdata      = r_mem_wdata;
   assign mem_wmask      = r_mem_wmask;
   assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid = 1'b0;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr = '0;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;
   logic        lsu_req_valid = 1'b0;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr = '0;
   logic        lsu_wen = 1'b0;
   logic [31:0] lsu_wdata = '0;
   logic [3:0]  lsu_wmask = '0;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int n_run  = 0;
   int n_fail = 0;

   mem_arbiter #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Returns 1 ns after the rising edge; inputs change here, checks follow a further #1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b1;
      tick();
      #1;
      n_run++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready});
      end
      tick();
      #1;
      n_run++;
      if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_err, lsu_err, mem_wen} !== 7'b0
          || mem_addr !== 32'h0 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0 || mem_wmask !== 4'h0) begin
         n_fail++; $display("FAIL reset_outputs: busy=%b mreq=%b iv=%b lv=%b addr=%h expected all 0",
                            busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_addr);
      end
      rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
      tick();
   endtask

   task automatic test_ifu_fetch();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
      #1;
      n_run++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         n_fail++; $display("FAIL fetch_accept: got %b expected 10", {ifu_req_ready, lsu_req_ready});
      end
      tick();
      ifu_req_valid = 1'b0;
      #1;
      n_run++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 4'b0000 || busy !== 1'b1) begin
         n_fail++; $display("FAIL fetch_memreq: valid=%b addr=%h wen=%b mask=%b busy=%b expected 1 80000000 0 0000 1",
                            mem_req_valid, mem_addr, mem_wen, mem_wmask, busy);
      end
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
      tick();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      n_run++;
      if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_err !== 1'b0
          || lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0) begin
         n_fail++; $display("FAIL fetch_resp: iv=%b rdata=%h err=%b lv=%b expected 1 00000413 0 0",
                            ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid);
      end
      tick();
      #1;
      n_run++;
      if (ifu_resp_valid !== 1'b0 || ifu_rdata !== 32'h0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL fetch_pulse_end: iv=%b rdata=%h busy=%b expected 0 0 0", ifu_resp_valid, ifu_rdata, busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq;
      int ng;
      int both;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
      seq = 4'b0; ng = 0; both = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (ifu_req_ready && lsu_req_ready) both++;
         if (ifu_req_ready || lsu_req_ready) begin
            if (ng < 4) seq[3-ng] = lsu_req_ready;
            ng++;
         end
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      #1;
      n_run++;
      if (both !== 0) begin
         n_fail++; $display("FAIL rr_exclusive: %0d cycles with both ready, expected 0", both);
      end
      n_run++;
      if (ng !== 4) begin
         n_fail++; $display("FAIL rr_count: %0d grants in 16 cycles, expected 4", ng);
      end
      n_run++;
      if (seq !== 4'b0101) begin
         n_fail++; $display("FAIL rr_order: got %b expected 0101 (0=IFU 1=LSU)", seq);
      end
      n_run++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rr_idle: busy=%b expected 0", busy);
      end
      tick();
   endtask

   task automatic test_lsu_write_stall();
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0;
      #1;
      n_run++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL write_accept: got %b expected 01", {ifu_req_ready, lsu_req_ready});
      end
      tick();
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_run++;
         if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011}) begin
            n_fail++; $display("FAIL write_stable[%0d]: valid=%b wen=%b addr=%h wdata=%h mask=%b expected 1 1 80001000 deadbeef 0011",
                               i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      n_run++;
      if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0 || ifu_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL write_resp: lv=%b rdata=%h err=%b iv=%b expected 1 00000000 0 0",
                            lsu_resp_valid, lsu_rdata, lsu_err, ifu_resp_valid);
      end
      tick();
      #1;
      n_run++;
      if (lsu_resp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL write_done: lv=%b busy=%b expected 0 0", lsu_resp_valid, busy);
      end
      tick();
   endtask

   task automatic test_timeout();
      int k;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; mem_req_ready = 1'b1;
      tick();
      lsu_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      k = -1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (lsu_resp_valid === 1'b1) begin
            k = i;
            break;
         end
         tick();
      end
      n_run++;
      if (k !== 8) begin
         n_fail++; $display("FAIL timeout_latency: response %0d cycles after WAIT entry, expected 8", k);
      end
      n_run++;
      if (lsu_err !== 1'b1 || lsu_rdata !== 32'h0 || ifu_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_resp: err=%b rdata=%h iv=%b expected 1 00000000 0", lsu_err, lsu_rdata, ifu_resp_valid);
      end
      tick();
      #1;
      n_run++;
      if (busy !== 1'b0 || lsu_resp_valid !== 1'b0 || lsu_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: busy=%b lv=%b err=%b expected 0 0 0", busy, lsu_resp_valid, lsu_err);
      end
      tick();
   endtask

   task automatic test_reset_in_wait();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; mem_req_ready = 1'b1;
      tick();
      ifu_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      tick();
      #1;
      n_run++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_in_wait: busy=%b mreq=%b expected 1 0", busy, mem_req_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_run++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_reset: busy=%b mreq=%b expected 0 0", busy, mem_req_valid);
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      n_run++;
      if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || busy !== 1'b0 || ifu_rdata !== 32'h0) begin
         n_fail++; $display("FAIL abort_late_resp: iv=%b lv=%b busy=%b rdata=%h expected 0 0 0 0",
                            ifu_resp_valid, lsu_resp_valid, busy, ifu_rdata);
      end
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0044; mem_req_ready = 1'b1;
      #1;
      n_run++;
      if (ifu_req_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_reaccept: ifu_req_ready=%b expected 1", ifu_req_ready);
      end
      tick();
      ifu_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
      tick();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      n_run++;
      if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0093 || ifu_err !== 1'b0) begin
         n_fail++; $display("FAIL abort_followup: iv=%b rdata=%h err=%b expected 1 00100093 0", ifu_resp_valid, ifu_rdata, ifu_err);
      end
      tick();
   endtask

   task automatic test_resp_vs_timeout();
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000; mem_req_ready = 1'b1;
      tick();
      lsu_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      repeat (7) tick();
      #1;
      n_run++;
      if (lsu_resp_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL coincide_early: lv=%b busy=%b expected 0 1", lsu_resp_valid, busy);
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      #1;
      n_run++;
      if (lsu_resp_valid !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== 32'hCAFE_0001) begin
         n_fail++; $display("FAIL coincide_resp: lv=%b err=%b rdata=%h expected 1 0 cafe0001", lsu_resp_valid, lsu_err, lsu_rdata);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_ifu_fetch();
      test_back_to_back();
      test_lsu_write_stall();
      test_timeout();
      test_reset_in_wait();
      test_resp_vs_timeout();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
